lcd_fb_scheduler: RTL and testbench
===================================

Name: lcd_fb_scheduler

Overview:
- Owns the single-port frame-buffer RAM that sits between the Julia compute engine (writer) and the TFT panel timing block (scan-out reader).
- After reset it clears the buffer, then raises the panel start strobe.
- It then arbitrates one RAM access per cycle, with display reads always taking strict priority over compute writes.
- It replaces the ad-hoc begin/RGB wiring at the top level.

Parameters:
- X_PX, 800, active pixels per line.
- Y_PX, 480, active lines per frame.
- DEPTH, X_PX*Y_PX (384000), frame-buffer words.
- ADDR_W, 19, RAM address width; must satisfy 2^ADDR_W >= DEPTH.
- DATA_W, 24, RGB888 word width.
- CLEAR_RGB, 24'h000000, fill colour written during clear.

Ports:
- i_CLK  in  1  system/pixel clock.
- i_RSTn  in  1  asynchronous active-low reset.
- i_Enable  in  1  level; 1 = run the clear sequence and then service traffic.
- i_FrameStart  in  1  pulse from panel timing at pixel (0,0); rewinds the read pointer.
- i_DispReq  in  1  panel needs the next pixel this cycle.
- o_DispRGB  out  DATA_W  pixel data to panel.
- o_DispValid  out  1  o_DispRGB updated this cycle.
- i_WrValid  in  1  compute write request.
- i_WrAddr  in  ADDR_W  write address.
- i_WrData  in  DATA_W  write data.
- o_WrReady  out  1  write accepted this cycle when high together with i_WrValid.
- o_WrDropped  out  1  pulse: an accepted write had i_WrAddr >= DEPTH.
- o_MemAddr  out  ADDR_W  RAM address.
- o_MemWE  out  1  RAM write enable.
- o_MemWData  out  DATA_W  RAM write data.
- i_MemRData  in  DATA_W  RAM read data, one-cycle latency.
- o_LcdBegin  out  1  drives the panel timing block's begin input.
- o_Busy  out  1  high while in CLEAR.

Behaviour:
- Reset: asynchronous; all outputs 0; state = IDLE; pointers = 0. Asserting reset mid-clear restarts from IDLE.
- States:
  - IDLE: stay while i_Enable=0. On i_Enable=1, go to CLEAR with clear pointer = 0.
  - CLEAR: each cycle o_MemWE=1, o_MemAddr=clear pointer, o_MemWData=CLEAR_RGB; pointer increments. When the write to DEPTH-1 completes, go to RUN; duration is exactly DEPTH cycles. o_Busy=1. o_WrReady=0. i_DispReq is ignored and produces no o_DispValid.
  - RUN: o_LcdBegin=1, registered, set on the first RUN cycle.
  - Any state: i_Enable=0 returns to IDLE next cycle and o_LcdBegin falls. Re-enabling re-clears the buffer.
- RUN arbitration, per cycle:
  - i_DispReq=1: read. o_MemAddr=read pointer, o_MemWE=0, o_WrReady=0.
  - Otherwise: o_WrReady=1. If i_WrValid=1, write i_WrData to i_WrAddr.
  - If i_WrAddr >= DEPTH, the write is accepted but o_MemWE stays 0, and o_WrDropped pulses the next cycle.
- o_WrReady is combinational: (state==RUN) & ~i_DispReq. The writer must hold its request until accepted.
- Read pointer:
  - Increments on each serviced read and wraps DEPTH-1 -> 0.
  - i_FrameStart forces the address to 0. If it coincides with i_DispReq, that read uses address 0 and the pointer becomes 1.
  - i_FrameStart outside RUN still zeroes the pointer.
- Read latency:
  - Read issued in cycle N; i_MemRData is valid in N+1 and registered into o_DispRGB.
  - o_DispRGB and o_DispValid therefore appear in N+2; o_DispValid is a one-cycle pulse per read.
  - o_DispRGB holds its last value otherwise.
- Back-to-back reads sustain one pixel per cycle; writes starve during sustained reads, by design.
- Address outputs, o_MemWE and o_MemWData are combinational from state, pointers and requests.

Decomposition:
- Shared package lcd_fb_pkg holds:
  - X_PX, Y_PX, DEPTH, ADDR_W, DATA_W;
  - the state enum {IDLE, CLEAR, RUN};
  - CLEAR_RGB default.
- One sub-module, fb_addr_counter: ADDR_W wrapping counter with synchronous clear, increment enable and wrap at DEPTH-1. Two instances are used: clear pointer and read pointer.

Test Plan:
- Reset, then i_Enable=1 with DEPTH overridden to 16 -> o_MemWE=1 for 16 consecutive cycles at addresses 0..15 with data 000000; o_Busy high for 16 cycles; o_LcdBegin rises the cycle after address 15.
- RUN, i_DispReq=0, i_WrValid=1, addr 5, data 0xAABBCC -> o_WrReady=1; o_MemWE=1, o_MemAddr=5, o_MemWData=AABBCC the same cycle.
- RUN, pulse i_FrameStart with i_DispReq=1 held 3 cycles, RAM model returning addr-based data -> o_MemAddr 0,1,2; o_DispValid pulses 2 cycles after each read with data of addresses 0,1,2; o_WrReady=0 throughout.
- Simultaneous i_DispReq=1 and i_WrValid=1 -> read serviced, no write; write completes the first cycle i_DispReq=0.
- Write to addr 16 (DEPTH=16) -> o_WrReady=1, o_MemWE=0, o_WrDropped pulses the next cycle.
- Drop i_RSTn during CLEAR at pointer 7 -> all outputs 0 immediately; after release with i_Enable=1, clear restarts at address 0. Separately, read pointer at 15 with i_DispReq=1 -> next read address 0.

Source files
------------

// File: rtl/lcd_fb_pkg.sv
// Shared frame-buffer geometry, widths and scheduler state encoding
// for the LCD frame-buffer scheduler slice.
package lcd_fb_pkg;

    localparam int X_PX   = 800;
    localparam int Y_PX   = 480;
    localparam int DEPTH  = X_PX * Y_PX;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 24;

    localparam logic [DATA_W-1:0] CLEAR_RGB = 24'h000000;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN
    } state_e;

endpackage

// File: rtl/fb_addr_counter.sv
// Frame-buffer address counter: wraps DEPTH-1 -> 0; a clear and an
// increment in the same cycle yield 1, so the cleared slot is consumed.
module fb_addr_counter #(
    parameter int ADDR_W = lcd_fb_pkg::ADDR_W,
    parameter int DEPTH  = lcd_fb_pkg::DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] cnt_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [ADDR_W-1:0] base;

    always_comb begin
        base  = clr_i ? '0 : cnt_q;
        cnt_d = base;
        if (inc_i) begin
            cnt_d = (base == LAST) ? '0 : base + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lcd_fb_scheduler.sv
// Single-port frame-buffer owner: clears the RAM, starts the panel,
// then gives scan-out reads strict priority over compute writes.
module lcd_fb_scheduler
    import lcd_fb_pkg::*;
#(
    parameter int                X_PX      = lcd_fb_pkg::X_PX,
    parameter int                Y_PX      = lcd_fb_pkg::Y_PX,
    parameter int                DEPTH     = X_PX * Y_PX,
    parameter int                ADDR_W    = lcd_fb_pkg::ADDR_W,
    parameter int                DATA_W    = lcd_fb_pkg::DATA_W,
    parameter logic [DATA_W-1:0] CLEAR_RGB = lcd_fb_pkg::CLEAR_RGB
) (
    input  logic              i_CLK,
    input  logic              i_RSTn,
    input  logic              i_Enable,
    input  logic              i_FrameStart,
    input  logic              i_DispReq,
    output logic [DATA_W-1:0] o_DispRGB,
    output logic              o_DispValid,
    input  logic              i_WrValid,
    input  logic [ADDR_W-1:0] i_WrAddr,
    input  logic [DATA_W-1:0] i_WrData,
    output logic              o_WrReady,
    output logic              o_WrDropped,
    output logic [ADDR_W-1:0] o_MemAddr,
    output logic              o_MemWE,
    output logic [DATA_W-1:0] o_MemWData,
    input  logic [DATA_W-1:0] i_MemRData,
    output logic              o_LcdBegin,
    output logic              o_Busy
);

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr, rd_ptr, rd_addr;
    logic              rd_fire, wr_fire, wr_oob;
    logic              rd_pend_q, disp_valid_q, wr_drop_q, lcd_begin_q;
    logic [DATA_W-1:0] disp_rgb_q;

    assign rd_fire = (state_q == RUN) && i_DispReq;
    assign wr_fire = (state_q == RUN) && !i_DispReq && i_WrValid;
    assign wr_oob  = {1'b0, i_WrAddr} >= DEPTH_W;
    assign rd_addr = i_FrameStart ? '0 : rd_ptr;

    fb_addr_counter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_clr_ptr (
        .clk_i (i_CLK),
        .rst_ni(i_RSTn),
        .clr_i (state_q != CLEAR),
        .inc_i (state_q == CLEAR),
        .cnt_o (clr_ptr)
    );

    fb_addr_counter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd_ptr (
        .clk_i (i_CLK),
        .rst_ni(i_RSTn),
        .clr_i (i_FrameStart),
        .inc_i (rd_fire),
        .cnt_o (rd_ptr)
    );

    always_comb begin
        state_d = state_q;
        if (!i_Enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = CLEAR;
                CLEAR:   if (clr_ptr == LAST) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        o_MemAddr  = '0;
        o_MemWE    = 1'b0;
        o_MemWData = '0;
        o_WrReady  = 1'b0;
        unique case (state_q)
            CLEAR: begin
                o_MemAddr  = clr_ptr;
                o_MemWE    = 1'b1;
                o_MemWData = CLEAR_RGB;
            end
            RUN: begin
                if (i_DispReq) begin
                    o_MemAddr = rd_addr;
                end else begin
                    o_WrReady = 1'b1;
                    if (i_WrValid) begin
                        o_MemAddr  = i_WrAddr;
                        o_MemWData = i_WrData;
                        o_MemWE    = !wr_oob;
                    end
                end
            end
            default: ;
        endcase
    end

    // RAM data lands one cycle after the read, then is registered here.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q      <= IDLE;
            lcd_begin_q  <= 1'b0;
            rd_pend_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_rgb_q   <= '0;
            wr_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lcd_begin_q  <= (state_d == RUN);
            rd_pend_q    <= rd_fire;
            disp_valid_q <= rd_pend_q;
            wr_drop_q    <= wr_fire && wr_oob;
            if (rd_pend_q) begin
                disp_rgb_q <= i_MemRData;
            end
        end
    end

    assign o_DispRGB   = disp_rgb_q;
    assign o_DispValid = disp_valid_q;
    assign o_WrDropped = wr_drop_q;
    assign o_LcdBegin  = lcd_begin_q;
    assign o_Busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_lcd_fb_scheduler.sv
// Directed bench for lcd_fb_scheduler with a 16-word buffer and a
// RAM model whose read data is 0xC00000 | address.
module tb_lcd_fb_scheduler;

    localparam int AW = 19;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, fs, dr, wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] disp_rgb, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          disp_valid, wr_ready, wr_drop, mem_we, lcd_begin, busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= 24'hC00000 | DW'(mem_addr);

    lcd_fb_scheduler #(.DEPTH(16)) dut (
        .i_CLK       (clk),
        .i_RSTn      (rst_n),
        .i_Enable    (en),
        .i_FrameStart(fs),
        .i_DispReq   (dr),
        .o_DispRGB   (disp_rgb),
        .o_DispValid (disp_valid),
        .i_WrValid   (wv),
        .i_WrAddr    (wa),
        .i_WrData    (wd),
        .o_WrReady   (wr_ready),
        .o_WrDropped (wr_drop),
        .o_MemAddr   (mem_addr),
        .o_MemWE     (mem_we),
        .o_MemWData  (mem_wdata),
        .i_MemRData  (mem_rdata),
        .o_LcdBegin  (lcd_begin),
        .o_Busy      (busy)
    );

    typedef struct {
        logic          dr, wv, fs;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] e_addr;
        logic          e_we, e_rdy, e_drop;
        logic [DW-1:0] e_wdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " addr"}, 32'(mem_addr), 0);
        chk({tag, " we"}, 32'(mem_we), 0);
        chk({tag, " wdata"}, 32'(mem_wdata), 0);
        chk({tag, " rgb"}, 32'(disp_rgb), 0);
        chk({tag, " valid"}, 32'(disp_valid), 0);
        chk({tag, " ready"}, 32'(wr_ready), 0);
        chk({tag, " drop"}, 32'(wr_drop), 0);
        chk({tag, " begin"}, 32'(lcd_begin), 0);
        chk({tag, " busy"}, 32'(busy), 0);
    endtask

    initial begin
        vec_t vt[8];
        vt[0] = '{0, 1, 0, 5,  24'hAABBCC, 5,  1, 1, 0, 24'hAABBCC};
        vt[1] = '{1, 1, 0, 7,  24'h123456, 0,  0, 0, 0, 24'h0};
        vt[2] = '{0, 1, 0, 7,  24'h123456, 7,  1, 1, 0, 24'h123456};
        vt[3] = '{0, 1, 0, 16, 24'h777777, 0,  0, 1, 0, 24'h0};
        vt[4] = '{0, 0, 0, 0,  24'h0,      0,  0, 1, 1, 24'h0};
        vt[5] = '{1, 0, 0, 0,  24'h0,      1,  0, 0, 0, 24'h0};
        vt[6] = '{1, 0, 1, 0,  24'h0,      0,  0, 0, 0, 24'h0};
        vt[7] = '{0, 1, 0, 15, 24'h00FF00, 15, 1, 1, 0, 24'h00FF00};

        rst_n = 1'b0; en = 0; fs = 0; dr = 0; wv = 0; wa = '0; wd = '0;
        repeat (2) cyc();
        #1 all_zero("reset");

        cyc(); rst_n = 1'b1; en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc(); #1;
            chk($sformatf("clr%0d addr", i), 32'(mem_addr), 32'(i));
            chk("clr we", 32'(mem_we), 1);
            chk("clr data", 32'(mem_wdata), 0);
            chk("clr busy", 32'(busy), 1);
            chk("clr begin", 32'(lcd_begin), 0);
        end
        cyc(); #1;
        chk("run begin", 32'(lcd_begin), 1);
        chk("run busy", 32'(busy), 0);

        foreach (vt[k]) begin
            cyc();
            dr = vt[k].dr; wv = vt[k].wv; fs = vt[k].fs;
            wa = vt[k].wa; wd = vt[k].wd;
            #1;
            chk($sformatf("vec%0d ready", k), 32'(wr_ready), 32'(vt[k].e_rdy));
            chk($sformatf("vec%0d we", k), 32'(mem_we), 32'(vt[k].e_we));
            chk($sformatf("vec%0d drop", k), 32'(wr_drop), 32'(vt[k].e_drop));
            if (vt[k].e_we || vt[k].dr)
                chk($sformatf("vec%0d addr", k), 32'(mem_addr),
                    32'(vt[k].e_addr));
            if (vt[k].e_we)
                chk($sformatf("vec%0d wdata", k), 32'(mem_wdata),
                    32'(vt[k].e_wdata));
        end

        // FrameStart with a 3-cycle read burst; data lands 2 cycles later.
        for (int c = 0; c < 6; c++) begin
            cyc();
            fs = (c == 0); dr = (c < 3); wv = 1'b0;
            #1;
            if (c < 3) begin
                chk($sformatf("burst%0d addr", c), 32'(mem_addr), 32'(c));
                chk("burst ready", 32'(wr_ready), 0);
            end
            if (c == 1 || c == 5) chk("burst idle valid", 32'(disp_valid), 0);
            if (c >= 2 && c <= 4) begin
                chk($sformatf("burst%0d valid", c), 32'(disp_valid), 1);
                chk($sformatf("burst%0d rgb", c), 32'(disp_rgb),
                    32'(24'hC00000 + DW'(c - 2)));
            end
            if (c == 5) chk("burst rgb hold", 32'(disp_rgb), 32'(24'hC00002));
        end

        // Read priority: pending write waits while DispReq is high.
        cyc(); dr = 1; wv = 1; wa = 9; wd = 24'h0A0B0C; #1;
        chk("prio read addr", 32'(mem_addr), 3);
        chk("prio no we", 32'(mem_we), 0);
        cyc(); dr = 0; #1;
        chk("prio wr we", 32'(mem_we), 1);
        chk("prio wr addr", 32'(mem_addr), 9);
        chk("prio wr data", 32'(mem_wdata), 32'(24'h0A0B0C));

        // Pointer now 4: read through 15, then wrap to 0.
        for (int a = 4; a <= 16; a++) begin
            cyc(); dr = 1; wv = 0; #1;
            chk($sformatf("wrap rd%0d", a), 32'(mem_addr), 32'(a % 16));
        end

        cyc(); dr = 0; en = 0;
        cyc(); #1;
        chk("disable begin", 32'(lcd_begin), 0);
        chk("disable ready", 32'(wr_ready), 0);

        // Re-clear with DispReq held; reset at clear pointer 7.
        cyc(); en = 1; dr = 1;
        for (int i = 0; i < 8; i++) begin
            cyc(); #1;
            chk($sformatf("reclr%0d addr", i), 32'(mem_addr), 32'(i));
            chk("reclr ready", 32'(wr_ready), 0);
            if (i >= 3) chk("reclr valid", 32'(disp_valid), 0);
        end
        rst_n = 1'b0; #1;
        all_zero("midreset");
        cyc(); rst_n = 1'b1; dr = 0;
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            chk($sformatf("restart%0d addr", i), 32'(mem_addr), 32'(i));
            chk("restart we", 32'(mem_we), 1);
            chk("restart busy", 32'(busy), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
